// File: rtl/z16_button_debouncer_if.sv
// z16_button_debouncer_if: raw button pin in, debounced level and press/release pulses out
interface z16_button_debouncer_if;
  logic i_button_raw;
  logic o_button;
  logic o_press;
  logic o_release;
  modport master (output i_button_raw, input o_button, o_press, o_release);
  modport slave  (input i_button_raw, output o_button, o_press, o_release);
endinterface

// File: rtl/z16_button_debouncer.sv
// z16_button_debouncer: synchronise and debounce the board button into a clean level plus press/release pulses
module z16_button_debouncer #(
  parameter int CNT_MAX    = 270000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  z16_button_debouncer_if.slave  bus
);
  localparam int W = $clog2(CNT_MAX + 1);
  localparam logic [W-1:0] LAST = W'(CNT_MAX - 1);
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  state_t state, state_nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic sync1, sync2, press_nxt, rel_nxt;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      state         <= RELEASED;
      cnt           <= '0;
      bus.o_button  <= 1'b0;
      bus.o_press   <= 1'b0;
      bus.o_release <= 1'b0;
    end else begin
      sync1         <= bus.i_button_raw ^ ACTIVE_LOW;
      sync2         <= sync1;
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bus.o_button  <= state_nxt == PRESSED || state_nxt == RELEASE_WAIT;
      bus.o_press   <= press_nxt;
      bus.o_release <= rel_nxt;
    end
  end
  // the counter restarts from zero on every state entry, so it never passes LAST
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    case (state)
      RELEASED: begin
        cnt_nxt = '0;
        if (sync2) state_nxt = PRESS_WAIT;
      end
      PRESS_WAIT:
        if (!sync2) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end
      PRESSED: begin
        cnt_nxt = '0;
        if (!sync2) state_nxt = RELEASE_WAIT;
      end
      RELEASE_WAIT:
        if (sync2) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
          rel_nxt   = 1'b1;
        end
    endcase
  end
endmodule

// File: tb/tb_z16_button_debouncer.sv
// tb_z16_button_debouncer: directed stimulus with a pulse scoreboard for active-low and active-high instances
module tb_z16_button_debouncer;
  typedef struct packed {int cyc; logic rel;} ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  ev_t qa[$];
  ev_t qb[$];
  z16_button_debouncer_if ifa ();
  z16_button_debouncer_if ifb ();
  z16_button_debouncer #(.CNT_MAX(4), .ACTIVE_LOW(1'b1)) dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
  z16_button_debouncer #(.CNT_MAX(4), .ACTIVE_LOW(1'b0)) dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, req);
    end
  endtask
  task automatic push_a(input logic rel);
    qa.push_back('{cyc: cyc + 1 + 6, rel: rel});
  endtask
  always @(negedge clk) begin
    if (ifa.o_press || ifa.o_release) begin
      ev_t e;
      checks++;
      if (ifa.o_press && ifa.o_release) begin
        failures++;
        $display("FAIL a_both_pulses at cycle %0d: press=1 release=1 expected one", cyc);
      end else if (qa.size() == 0) begin
        failures++;
        $display("FAIL a_unexpected_pulse at cycle %0d: press=%b release=%b expected none", cyc, ifa.o_press, ifa.o_release);
      end else begin
        e = qa.pop_front();
        if (e.cyc != cyc || e.rel != ifa.o_release || ifa.o_button != !e.rel) begin
          failures++;
          $display("FAIL a_pulse at cycle %0d: release=%b button=%b expected cycle %0d release=%b button=%b",
                   cyc, ifa.o_release, ifa.o_button, e.cyc, e.rel, !e.rel);
        end
      end
    end
  end
  always @(negedge clk) begin
    if (ifb.o_press || ifb.o_release) begin
      ev_t e;
      checks++;
      if (ifb.o_press && ifb.o_release) begin
        failures++;
        $display("FAIL b_both_pulses at cycle %0d: press=1 release=1 expected one", cyc);
      end else if (qb.size() == 0) begin
        failures++;
        $display("FAIL b_unexpected_pulse at cycle %0d: press=%b release=%b expected none", cyc, ifb.o_press, ifb.o_release);
      end else begin
        e = qb.pop_front();
        if (e.cyc != cyc || e.rel != ifb.o_release || ifb.o_button != !e.rel) begin
          failures++;
          $display("FAIL b_pulse at cycle %0d: release=%b button=%b expected cycle %0d release=%b button=%b",
                   cyc, ifb.o_release, ifb.o_button, e.cyc, e.rel, !e.rel);
        end
      end
    end
  end
  initial begin
    ifa.i_button_raw = 1'b1;
    ifb.i_button_raw = 1'b0;
    tick(3);
    chk("reset_button", ifa.o_button, 1'b0);
    chk("reset_press", ifa.o_press, 1'b0);
    chk("reset_release", ifa.o_release, 1'b0);
    chk("reset_b_button", ifb.o_button, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) chk("idle_button", ifa.o_button | ifb.o_button, 1'b0);
    tick(20);
    chk("idle_after_20", ifa.o_button, 1'b0);
    // clean press
    ifa.i_button_raw = 1'b0;
    push_a(1'b0);
    tick(5);
    chk("press_not_yet", ifa.o_button, 1'b0);
    tick(5);
    chk("press_held", ifa.o_button, 1'b1);
    // clean release
    ifa.i_button_raw = 1'b1;
    push_a(1'b1);
    tick(10);
    chk("release_level", ifa.o_button, 1'b0);
    // bounce from released: each low lasts 2 cycles
    for (int i = 0; i < 2; i++) begin
      ifa.i_button_raw = 1'b0;
      tick(2);
      ifa.i_button_raw = 1'b1;
      tick(2);
    end
    tick(6);
    chk("bounce_no_press", ifa.o_button, 1'b0);
    ifa.i_button_raw = 1'b0;
    push_a(1'b0);
    tick(10);
    chk("bounce_then_press", ifa.o_button, 1'b1);
    // 3-cycle release glitch while pressed
    ifa.i_button_raw = 1'b1;
    tick(3);
    ifa.i_button_raw = 1'b0;
    tick(10);
    chk("glitch_still_pressed", ifa.o_button, 1'b1);
    ifa.i_button_raw = 1'b1;
    push_a(1'b1);
    tick(10);
    chk("second_release", ifa.o_button, 1'b0);
    // reset sampled four edges into a press debounce
    ifa.i_button_raw = 1'b0;
    begin
      int e;
      e = cyc + 1;
      tick(4);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("midreset_button", ifa.o_button, 1'b0);
      chk("midreset_press", ifa.o_press, 1'b0);
      qa.push_back('{cyc: e + 11, rel: 1'b0});
    end
    tick(12);
    chk("midreset_repress", ifa.o_button, 1'b1);
    // active-high instance
    ifb.i_button_raw = 1'b1;
    qb.push_back('{cyc: cyc + 1 + 6, rel: 1'b0});
    tick(10);
    chk("b_press_level", ifb.o_button, 1'b1);
    ifb.i_button_raw = 1'b0;
    qb.push_back('{cyc: cyc + 1 + 6, rel: 1'b1});
    tick(10);
    chk("b_release_level", ifb.o_button, 1'b0);
    checks++;
    if (qa.size() != 0) begin
      failures++;
      $display("FAIL a_missing_pulses: %0d outstanding expected 0", qa.size());
    end
    checks++;
    if (qb.size() != 0) begin
      failures++;
      $display("FAIL b_missing_pulses: %0d outstanding expected 0", qb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/z16_button_debouncer.md
# z16_button_debouncer

Synchronises and debounces the raw board push-button and produces the clean level that drives the Z16 CPU `i_button` input, which the CPU reads through MMIO address 0x007C. It also produces one-cycle press and release pulses for future interrupt or counter logic. The block sits between the board pin and the CPU top level, in the CPU clock domain.

## Interface

Parameters:
- `CNT_MAX`, default 270000: number of consecutive stable cycles required to accept a level change (10 ms at 27 MHz). Must be ≥ 1.
- `ACTIVE_LOW`, default 1: 1 means the raw pin reads 0 when the button is pressed; 0 means the pin is active-high.

Ports:
- `i_clk`, input, 1: the single clock for all logic.
- `i_rst`, input, 1: reset, synchronous and active-high.
- `i_button_raw`, input, 1: asynchronous, bouncing button pin.
- `o_button`, output, 1: debounced level, 1 = pressed; connects to CPU `i_button`. Registered.
- `o_press`, output, 1: one-cycle pulse when a press is accepted. Registered.
- `o_release`, output, 1: one-cycle pulse when a release is accepted. Registered.

## Operation

- **Normalise:** `n = i_button_raw ^ ACTIVE_LOW`, so n = 1 means pressed.
- **Synchronise:** n passes through a 2-flop synchroniser, `sync1 -> sync2`. Only `sync2` (called s below) is used by later logic.
- **Counter:** width is $clog2(CNT_MAX+1). It is cleared on every state entry.
- **FSM, 4 states:**
  - RELEASED: `o_button` = 0.
    - s = 1 -> PRESS_WAIT, counter = 0.
  - PRESS_WAIT: `o_button` = 0.
    - s = 0 -> RELEASED. This is a bounce: no pulse is produced.
    - Otherwise, counter == CNT_MAX-1 -> PRESSED, assert `o_press` for one cycle.
    - Otherwise, counter increments.
  - PRESSED: `o_button` = 1.
    - s = 0 -> RELEASE_WAIT, counter = 0.
  - RELEASE_WAIT: `o_button` = 1.
    - s = 1 -> PRESSED. This is a bounce: no pulse is produced.
    - Otherwise, counter == CNT_MAX-1 -> RELEASED, assert `o_release` for one cycle.
    - Otherwise, counter increments.
- **Output rules:**
  - `o_press` and `o_release` are never high in the same cycle.
  - Each pulse is high for exactly one cycle per accepted transition.
- **Counter range:** the counter never exceeds CNT_MAX-1. No wrap-around is possible.
- **Reset:** `i_rst` high at a clock edge forces the following, regardless of any in-progress debounce, which is abandoned:
  - `sync1` = `sync2` = 0 (the normalised released level);
  - state = RELEASED, counter = 0;
  - `o_button` = `o_press` = `o_release` = 0.
- **Button held through reset:** after reset deasserts, the held button is treated as a new press and generates `o_press` with the normal latency.

## Timing

- **Press latency:** n goes to 1 and is sampled at edge E. With n held stable, `o_button` and `o_press` go high after edge E+2+CNT_MAX. `o_press` falls after the next edge.
- **Release latency:** symmetric. `o_button` goes low and `o_release` pulses after edge E+2+CNT_MAX.
- **Glitch rejection:** a level that is stable for CNT_MAX cycles or fewer, as seen at s, changes nothing. The next change restarts the count from 0.
- **Throughput:** a full press/release cycle takes at least 2·(CNT_MAX+1) cycles from s transitions to both pulses.
- **Conflicting events:** reset has priority over every transition.
- **Metastability:** none of the outputs depends combinationally on `i_button_raw`. Outputs change only on `i_clk` edges.

## Test plan

All scenarios use CNT_MAX = 4 and ACTIVE_LOW = 1.

- **Reset values:** raw = 1 with `i_rst` high for 3 cycles -> `o_button` = `o_press` = `o_release` = 0. Outputs stay 0 for 20 cycles after reset deasserts.
- **Clean press:** raw 1 -> 0 sampled at edge E and held -> `o_button` = 1 and `o_press` = 1 after edge E+6. `o_press` = 0 after E+7. `o_button` stays 1.
- **Bounce rejection:** from released, raw toggles 0,1,0,1 every 2 cycles, then rests at 1 -> no pulse, `o_button` stays 0. Then raw = 0 held -> press accepted exactly 6 edges after the final 0 is sampled.
- **Clean release:** from pressed, raw = 1 held -> `o_button` = 0 and `o_release` = 1 after edge E+6, for one cycle only. Also, a 3-cycle low glitch while pressed produces no `o_release`.
- **Reset mid-debounce:** raw = 0 held, `i_rst` pulsed at edge E+4 -> all outputs 0 and no pulse at E+6. `o_press` then occurs after edge (E+4)+7: one edge after reset, plus 2+CNT_MAX.
- **Active-high variant:** ACTIVE_LOW = 0, raw 0 -> 1 held -> same E+6 press timing. No pulse occurs from the reset level 0.
